alu_share_arb: RTL

Two-port arbiter and sequencer that shares one combinational 32-bit ALU (ADD/SUB/AND/OR/SLT, 3-bit op codes) between two requesters. It accepts one operation at a time through a valid/ready handshake and picks between simultaneous requesters round-robin. It registers the operands into the ALU, captures the ALU output, and returns it with the requester ID. It sits between the datapath's issue logic and the single ALU instance, and it drives that ALU's operand, select and reset inputs.

---
 rtl/alu_share_arb.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter/sequencer sharing one 32-bit ALU.
// Ports: clk/reset, two valid/ready request ports (a, b, sel), response
// port (valid/ready, id, data, err), ALU drive (alu_a/b/sel/reset),
// alu_dout from the ALU, busy status.
module alu_share_arb #(
   parameter logic [2:0] OP_AND = 3'b000,
   parameter logic [2:0] OP_OR  = 3'b001,
   parameter logic [2:0] OP_ADD = 3'b010,
   parameter logic [2:0] OP_SUB = 3'b110,
   parameter logic [2:0] OP_SLT = 3'b111
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [2:0]  req0_sel,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [2:0]  req1_sel,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_sel,
   output logic        alu_reset,
   input  logic [31:0] alu_dout,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_nx;

   logic last_grant;
   logic gnt_any;
   logic gnt_id;
   logic sel_legal;

   logic [31:0] pick_a;
   logic [31:0] pick_b;
   logic [2:0]  pick_sel;

   // Grant: a lone requester wins; on a tie the one
   // that did not win last time wins.
   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = 1'b0;
      if (state == IDLE && !reset) begin
         if (req0_valid && req1_valid) begin
            gnt_any = 1'b1;
            gnt_id  = ~last_grant;
         end else if (req0_valid) begin
            gnt_any = 1'b1;
            gnt_id  = 1'b0;
         end else if (req1_valid) begin
            gnt_any = 1'b1;
            gnt_id  = 1'b1;
         end
      end
   end

   assign req0_ready = gnt_any && !gnt_id;
   assign req1_ready = gnt_any && gnt_id;

   always_comb begin
      pick_a   = req0_a;
      pick_b   = req0_b;
      pick_sel = req0_sel;
      if (gnt_id) begin
         pick_a   = req1_a;
         pick_b   = req1_b;
         pick_sel = req1_sel;
      end
   end

   always_comb begin
      sel_legal = 1'b0;
      unique case (alu_sel)
         OP_AND, OP_OR, OP_ADD,
         OP_SUB, OP_SLT: sel_legal = 1'b1;
         default:        sel_legal = 1'b0;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // next state
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (gnt_any)   state_nx = EXEC;
         EXEC:                state_nx = RESP;
         RESP: if (rsp_ready) state_nx = IDLE;
         default:             state_nx = IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      rsp_valid = (state == RESP);
      busy      = (state != IDLE);
      alu_reset = (state != EXEC);
   end

   // operand capture, arbiter pointer and result capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_sel    <= '0;
         rsp_id     <= 1'b0;
         last_grant <= 1'b1;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
      end else begin
         if (gnt_any) begin
            alu_a      <= pick_a;
            alu_b      <= pick_b;
            alu_sel    <= pick_sel;
            rsp_id     <= gnt_id;
            last_grant <= gnt_id;
         end
         if (state == EXEC) begin
            rsp_data <= sel_legal ? alu_dout : '0;
            rsp_err  <= !sel_legal;
         end
      end
   end

endmodule
